imm_inst_packer: RTL and testbench

Inverse of the immediate extractor: packs a 32-bit immediate and register/function fields into one RV32 instruction word of a given immediate format. Range-checks the immediate against the format. Writes accepted words sequentially into instruction memory via a write/ack port. Used by the boot/test program loader and by the self-modifying-code test harness.

---
 rtl/imm_inst_packer_if.sv | 47 ++++
 rtl/imm_inst_packer.sv | 170 +++++++++++++++++
 tb/tb_imm_inst_packer.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_inst_packer_if.sv
// rtl/imm_inst_packer_if.sv - request and instruction-memory write bus for imm_inst_packer
// Also provides the shared immediate-format codes (IS_I/IS_S/IS_B/IS_U/IS_J).
`ifndef IS_I
`define IS_I 3'd0
`endif
`ifndef IS_S
`define IS_S 3'd1
`endif
`ifndef IS_B
`define IS_B 3'd2
`endif
`ifndef IS_U
`define IS_U 3'd3
`endif
`ifndef IS_J
`define IS_J 3'd4
`endif

interface imm_inst_packer_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_imm_src;
  logic [6:0]  req_opcode;
  logic [4:0]  req_rd;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_ack;

  modport master (
    output req_valid, req_imm_src, req_opcode, req_rd, req_funct3, req_rs1, req_rs2, req_imm,
    input  req_ready,
    input  imem_we, imem_addr, imem_wdata,
    output imem_ack
  );

  modport slave (
    input  req_valid, req_imm_src, req_opcode, req_rd, req_funct3, req_rs1, req_rs2, req_imm,
    output req_ready,
    output imem_we, imem_addr, imem_wdata,
    input  imem_ack
  );
endinterface

// File: rtl/imm_inst_packer.sv
// rtl/imm_inst_packer.sv - packs immediate + fields into RV32 words and writes them to imem
// Optional SELF_CHECK_EN: second PACK cycle re-extracts the immediate and rejects mismatches.
module imm_inst_packer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256,
  parameter int          CNT_W     = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  imm_inst_packer_if.slave bus,
  output logic [CNT_W-1:0] wr_count,
  output logic             full,
  output logic             err,
  output logic [2:0]       err_code
);

  typedef enum logic [1:0] {IDLE, PACK, CHK, WRITE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  src_q;
  logic [6:0]  op_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic [2:0]  f3_q;
  logic [31:0] imm_q, wdata_q, addr_q, packed_word;
  logic [2:0]  pack_code;
  logic        accept;

  assign full           = (wr_count == CNT_W'(DEPTH));
  assign accept         = bus.req_valid && bus.req_ready;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

  // Misalignment takes priority over range for B and J.
  always_comb begin
    packed_word = 32'h0;
    pack_code   = 3'd0;
    case (src_q)
      `IS_I: begin
        packed_word = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
        if (imm_q[31:11] != {21{imm_q[11]}}) pack_code = 3'd1;
      end
      `IS_S: begin
        packed_word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], op_q};
        if (imm_q[31:11] != {21{imm_q[11]}}) pack_code = 3'd1;
      end
      `IS_B: begin
        packed_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11], op_q};
        if (imm_q[0])                             pack_code = 3'd3;
        else if (imm_q[31:12] != {20{imm_q[12]}}) pack_code = 3'd1;
      end
      `IS_U: begin
        packed_word = {imm_q[31:12], rd_q, op_q};
        if (imm_q[11:0] != 12'h0) pack_code = 3'd1;
      end
      `IS_J: begin
        packed_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, op_q};
        if (imm_q[0])                             pack_code = 3'd3;
        else if (imm_q[31:20] != {12{imm_q[20]}}) pack_code = 3'd1;
      end
      default: pack_code = 3'd2;
    endcase
  end

`ifdef SELF_CHECK_EN
  logic [31:0] reimm;
  logic        mismatch;
  always_comb begin
    reimm = 32'h0;
    case (src_q)
      `IS_I:   reimm = {{20{wdata_q[31]}}, wdata_q[31:20]};
      `IS_S:   reimm = {{20{wdata_q[31]}}, wdata_q[31:25], wdata_q[11:7]};
      `IS_B:   reimm = {{20{wdata_q[31]}}, wdata_q[7], wdata_q[30:25], wdata_q[11:8], 1'b0};
      `IS_U:   reimm = {wdata_q[31:12], 12'h0};
      `IS_J:   reimm = {{12{wdata_q[31]}}, wdata_q[19:12], wdata_q[20], wdata_q[30:21], 1'b0};
      default: reimm = 32'h0;
    endcase
  end
  assign mismatch = (reimm != imm_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = PACK;
      PACK: begin
        if (pack_code != 3'd0) state_d = IDLE;
`ifdef SELF_CHECK_EN
        else                   state_d = CHK;
`else
        else                   state_d = WRITE;
`endif
      end
`ifdef SELF_CHECK_EN
      CHK:   state_d = mismatch ? IDLE : WRITE;
`endif
      WRITE: if (bus.imem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  // clear blocks the handshake so a simultaneous request is never half-accepted.
  always_comb begin
    bus.req_ready = rst_n && !clear && (state_q == IDLE) && !full;
    bus.imem_we   = (state_q == WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q    <= 3'd0;
      op_q     <= 7'd0;
      rd_q     <= 5'd0;
      f3_q     <= 3'd0;
      rs1_q    <= 5'd0;
      rs2_q    <= 5'd0;
      imm_q    <= 32'h0;
      wdata_q  <= 32'h0;
      addr_q   <= BASE_ADDR;
      wr_count <= '0;
      err      <= 1'b0;
      err_code <= 3'd0;
    end else begin
      err <= 1'b0;
      if (clear) begin
        addr_q   <= BASE_ADDR;
        wr_count <= '0;
        err_code <= 3'd0;
      end else begin
        case (state_q)
          IDLE: if (accept) begin
            src_q <= bus.req_imm_src;
            op_q  <= bus.req_opcode;
            rd_q  <= bus.req_rd;
            f3_q  <= bus.req_funct3;
            rs1_q <= bus.req_rs1;
            rs2_q <= bus.req_rs2;
            imm_q <= bus.req_imm;
          end
          PACK: begin
            if (pack_code != 3'd0) begin
              err      <= 1'b1;
              err_code <= pack_code;
            end else begin
              err_code <= 3'd0;
              wdata_q  <= packed_word;
            end
          end
`ifdef SELF_CHECK_EN
          CHK: if (mismatch) begin
            err      <= 1'b1;
            err_code <= 3'd4;
          end
`endif
          WRITE: if (bus.imem_ack) begin
            addr_q   <= addr_q + 32'd4;
            wr_count <= wr_count + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imm_inst_packer.sv
// tb/tb_imm_inst_packer.sv - self-checking bench for imm_inst_packer (DEPTH=4)
`ifndef IS_I
`define IS_I 3'd0
`endif
`ifndef IS_S
`define IS_S 3'd1
`endif
`ifndef IS_B
`define IS_B 3'd2
`endif
`ifndef IS_U
`define IS_U 3'd3
`endif
`ifndef IS_J
`define IS_J 3'd4
`endif

module tb_imm_inst_packer;
  localparam int          DEPTH = 4;
  localparam int          CNT_W = 3;
  localparam logic [31:0] BASE  = 32'h0;
`ifdef SELF_CHECK_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic [2:0]  src;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [2:0]  code;
  } req_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] wr_count;
  logic             full, err;
  logic [2:0]       err_code;

  imm_inst_packer_if bus();

  imm_inst_packer #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus),
    .wr_count(wr_count), .full(full), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference packing from the field tables using shifts/masks and signed ranges.
  function automatic void predict(input logic [2:0] src, input logic [6:0] op, input logic [4:0] rd,
                                  input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [31:0] imm, output logic [2:0] code, output logic [31:0] w);
    int s;
    logic [31:0] o, d, f, a, b;
    s = int'($signed(imm));
    o = 32'(op); d = 32'(rd) << 7; f = 32'(f3) << 12; a = 32'(rs1) << 15; b = 32'(rs2) << 20;
    code = 3'd0;
    w = 32'h0;
    case (src)
      `IS_I: begin
        if (s < -2048 || s > 2047) code = 3'd1;
        w = (imm << 20) | a | f | d | o;
      end
      `IS_S: begin
        if (s < -2048 || s > 2047) code = 3'd1;
        w = ((imm >> 5) << 25) | b | a | f | ((imm & 32'd31) << 7) | o;
      end
      `IS_B: begin
        if (s % 2 != 0) code = 3'd3;
        else if (s < -4096 || s > 4095) code = 3'd1;
        w = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'd63) << 25) | b | a | f |
            (((imm >> 1) & 32'd15) << 8) | (((imm >> 11) & 32'd1) << 7) | o;
      end
      `IS_U: begin
        if (imm % 4096 != 0) code = 3'd1;
        w = ((imm >> 12) << 12) | d | o;
      end
      `IS_J: begin
        if (s % 2 != 0) code = 3'd3;
        else if (s < -1048576 || s > 1048575) code = 3'd1;
        w = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'd1023) << 21) |
            (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'd255) << 12) | d | o;
      end
      default: code = 3'd2;
    endcase
  endfunction

  bit          pend = 1'b0, pend_err = 1'b0, ack_en = 1'b1;
  bit          exp_err, exp_we, exp_ready;
  logic [2:0]  pend_code;
  logic [31:0] pend_data = 32'h0;
  logic [31:0] exp_addr = BASE;
  logic [2:0]  exp_code = 3'd0;
  int          exp_count = 0, cyc = 0, acc_cyc = 0, ev_at = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      bus.imem_ack = 1'b0;
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_we", 32'(bus.imem_we), 32'd0);
      chk("rst_addr", bus.imem_addr, BASE);
      chk("rst_wdata", bus.imem_wdata, 32'h0);
      chk("rst_count", 32'(wr_count), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_code", 32'(err_code), 32'd0);
    end else begin
      cyc++;
      exp_err = 1'b0;
      if (pend && pend_err && cyc == ev_at) begin
        exp_err  = 1'b1;
        exp_code = pend_code;
        pend     = 1'b0;
      end
      if (pend && !pend_err && cyc == acc_cyc + 2) exp_code = 3'd0;
      exp_we    = pend && !pend_err && cyc >= ev_at;
      exp_ready = !pend && exp_count < DEPTH && !clear;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      chk("imem_we", 32'(bus.imem_we), 32'(exp_we));
      chk("err", 32'(err), 32'(exp_err));
      chk("err_code", 32'(err_code), 32'(exp_code));
      chk("wr_count", 32'(wr_count), 32'(exp_count));
      chk("full", 32'(full), 32'(exp_count == DEPTH));
      chk("imem_addr", bus.imem_addr, exp_addr);
      if (exp_we) chk("imem_wdata", bus.imem_wdata, pend_data);
      bus.imem_ack = bus.imem_we && ack_en;
      if (clear) begin
        pend      = 1'b0;
        exp_count = 0;
        exp_addr  = BASE;
        exp_code  = 3'd0;
      end else begin
        if (exp_we && bus.imem_ack) begin
          pend = 1'b0;
          exp_count++;
          exp_addr += 32'd4;
        end
        if (bus.req_valid && exp_ready) begin
          predict(bus.req_imm_src, bus.req_opcode, bus.req_rd, bus.req_funct3,
                  bus.req_rs1, bus.req_rs2, bus.req_imm, pend_code, pend_data);
          pend_err = (pend_code != 3'd0);
          pend     = 1'b1;
          acc_cyc  = cyc;
          ev_at    = cyc + (pend_err ? 2 : LAT);
        end
      end
    end
  end

  task automatic drive(input req_t r);
    bus.req_imm_src = r.src;
    bus.req_opcode  = r.op;
    bus.req_rd      = r.rd;
    bus.req_funct3  = r.f3;
    bus.req_rs1     = r.rs1;
    bus.req_rs2     = r.rs2;
    bus.req_imm     = r.imm;
  endtask

  task automatic send(input req_t r, input int budget, output bit acc);
    @(posedge clk); #1;
    drive(r);
    bus.req_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk); #1;
      if (!pend) done = 1'b1;
    end
    chk("idle_wait", 32'(done), 32'd1);
    @(negedge clk); #1;
  endtask

  task automatic run(input req_t r);
    bit acc;
    send(r, 20, acc);
    chk("accept", 32'(acc), 32'd1);
    wait_idle();
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
  endtask

  task automatic wait_we(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk); #1;
      if (bus.imem_we) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  req_t        errs [10];
  req_t        bnd  [4];
  req_t        r;
  logic [2:0]  pc;
  logic [31:0] pw;
  bit          acc;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0;
    drive('0);

    predict(`IS_I, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, pc, pw);
    chk("pin_I_word", pw, 32'hFFF0_0093);
    predict(`IS_S, 7'h23, 5'd0, 3'd2, 5'd3, 5'd2, 32'd8, pc, pw);
    chk("pin_S_word", pw, 32'h0021_A423);
    predict(`IS_J, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'h800, pc, pw);
    chk("pin_J_word", pw, 32'h0010_00EF);
    predict(`IS_U, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 32'h1234_5000, pc, pw);
    chk("pin_U_word", pw, 32'h1234_52B7);
    predict(`IS_B, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 32'd3, pc, pw);
    chk("pin_B_misaligned", 32'(pc), 32'd3);
    predict(`IS_I, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd2048, pc, pw);
    chk("pin_I_range", 32'(pc), 32'd1);
    predict(3'b111, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd0, pc, pw);
    chk("pin_bad_fmt", 32'(pc), 32'd2);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run('{`IS_I, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 3'd0});
    chk("first_count", 32'(wr_count), 32'd1);
    chk("first_next_addr", bus.imem_addr, 32'h4);
    run('{`IS_S, 7'h23, 5'd0, 3'd2, 5'd3, 5'd2, 32'd8, 3'd0});
    run('{`IS_J, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'h800, 3'd0});
    chk("three_count", 32'(wr_count), 32'd3);
    chk("three_addr", bus.imem_addr, 32'hC);

    errs[0] = '{`IS_B, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 32'd3, 3'd3};
    errs[1] = '{`IS_I, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd2048, 3'd1};
    errs[2] = '{3'b111, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd0, 3'd2};
    errs[3] = '{`IS_U, 7'h37, 5'd1, 3'd0, 5'd0, 5'd0, 32'h0000_0801, 3'd1};
    errs[4] = '{`IS_J, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'h0010_0000, 3'd1};
    errs[5] = '{`IS_B, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 32'd4096, 3'd1};
    errs[6] = '{`IS_J, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'd3, 3'd3};
    errs[7] = '{`IS_B, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 32'h1001, 3'd3};
    errs[8] = '{`IS_S, 7'h23, 5'd0, 3'd2, 5'd3, 5'd2, 32'hFFFF_F7FF, 3'd1};
    errs[9] = '{3'd5, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd0, 3'd2};
    for (int i = 0; i < 10; i++) begin
      run(errs[i]);
      chk("err_code_held", 32'(err_code), 32'(errs[i].code));
      chk("err_count_same", 32'(wr_count), 32'd3);
    end

    pulse_clear();
    run('{`IS_U, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 32'h1234_5000, 3'd0});
    run('{`IS_B, 7'h63, 5'd0, 3'd1, 5'd1, 5'd2, 32'hFFFF_FFF8, 3'd0});
    chk("ub_addr", bus.imem_addr, 32'h8);

    // write held without ack, then abandoned by clear
    ack_en = 1'b0;
    send('{`IS_I, 7'h13, 5'd2, 3'd0, 5'd1, 5'd0, 32'd5, 3'd0}, 20, acc);
    chk("hold_accept", 32'(acc), 32'd1);
    wait_we("hold_we_seen");
    chk("hold_addr", bus.imem_addr, 32'h8);
    chk("hold_wdata", bus.imem_wdata, 32'h0050_8113);
    repeat (5) @(negedge clk);
    pulse_clear();
    ack_en = 1'b1;
    @(negedge clk); #1;
    chk("clr_we", 32'(bus.imem_we), 32'd0);
    chk("clr_addr", bus.imem_addr, BASE);
    chk("clr_count", 32'(wr_count), 32'd0);

    bnd[0] = '{`IS_I, 7'h13, 5'd3, 3'd0, 5'd0, 5'd0, 32'd2047, 3'd0};
    bnd[1] = '{`IS_I, 7'h13, 5'd4, 3'd0, 5'd0, 5'd0, 32'hFFFF_F800, 3'd0};
    bnd[2] = '{`IS_B, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 32'd4094, 3'd0};
    bnd[3] = '{`IS_J, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'hFFF0_0000, 3'd0};
    for (int i = 0; i < 4; i++) run(bnd[i]);
    chk("full_lit", 32'(full), 32'd1);
    chk("full_ready", 32'(bus.req_ready), 32'd0);
    chk("full_addr", bus.imem_addr, 32'h10);
    send(bnd[0], 6, acc);
    chk("full_stall", 32'(acc), 32'd0);

    // clear and a request arrive together: only the later cycle accepts
    r = '{`IS_I, 7'h13, 5'd7, 3'd0, 5'd0, 5'd0, 32'd1, 3'd0};
    @(posedge clk); #1;
    drive(r);
    bus.req_valid = 1'b1;
    clear = 1'b1;
    @(negedge clk); #1;
    chk("ready_during_clear", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1 clear = 1'b0;
    acc = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk); #1 bus.req_valid = 1'b0;
    chk("post_clear_accept", 32'(acc), 32'd1);
    wait_we("post_clear_we");
    chk("post_clear_addr", bus.imem_addr, BASE);
    wait_idle();
    chk("post_clear_count", 32'(wr_count), 32'd1);
    chk("post_clear_full", 32'(full), 32'd0);

    repeat (3) @(negedge clk);
    chk("nothing_pending", 32'(pend), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
